// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle ops, radix-2 Booth MUL, non-restoring signed DIV
// Optional condition flags enabled by defining SEQ_ALU_FLAGS_EN.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_INC  = 4'd13;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic             last;

  // Booth working registers: mh is one bit wider so MIN multiplicands cannot overflow
  logic [WIDTH:0]   mh;
  logic [WIDTH-1:0] ml;
  logic             qm1;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   b_sum;
  logic [WIDTH:0]   b_h;
  logic [WIDTH-1:0] b_l;

  // Divider works on magnitudes; signs are applied in FIX
  logic [WIDTH:0]   dr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dd;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH:0]   d_sh;
  logic [WIDTH:0]   d_r;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [SHAMT_W-1:0] sh;
  logic [SHAMT_W:0]   rot_amt;
  logic [WIDTH-1:0]   sc_res;

  assign last = (cnt == LAST);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_next = S_MUL;
          end else if ((op == OP_DIV) && (b != '0)) begin
            state_next = S_DIV;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (last) state_next = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sh      = b[SHAMT_W-1:0];
    rot_amt = (SHAMT_W + 1)'(WIDTH) - {1'b0, sh};
    sc_res  = '0;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOT:  sc_res = ~a;
      OP_NEG:  sc_res = '0 - a;
      OP_SHR:  sc_res = a >> sh;
      OP_SHRA: sc_res = $signed(a) >>> sh;
      OP_SHL:  sc_res = a << sh;
      OP_ROR:  sc_res = (a >> sh) | (a << rot_amt);
      OP_ROL:  sc_res = (a << sh) | (a >> rot_amt);
      OP_INC:  sc_res = b + ONE;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    a_mag = a[MSB] ? ('0 - a) : a;
    b_mag = b[MSB] ? ('0 - b) : b;
    case ({ml[0], qm1})
      2'b01:   b_sum = mh + {mcand[MSB], mcand};
      2'b10:   b_sum = mh - {mcand[MSB], mcand};
      default: b_sum = mh;
    endcase
    b_h    = {b_sum[WIDTH], b_sum[WIDTH:1]};
    b_l    = {b_sum[0], ml[WIDTH-1:1]};
    d_sh   = {dr[WIDTH-1:0], dq[MSB]};
    d_r    = dr[WIDTH] ? (d_sh + {1'b0, dd}) : (d_sh - {1'b0, dd});
    d_q    = {dq[WIDTH-2:0], ~d_r[WIDTH]};
    rem    = dr[WIDTH] ? (dr[WIDTH-1:0] + dd) : dr[WIDTH-1:0];
    fix_lo = neg_q ? ('0 - dq) : dq;
    fix_hi = neg_r ? ('0 - rem) : rem;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      mh        <= '0;
      ml        <= '0;
      qm1       <= 1'b0;
      mcand     <= '0;
      dr        <= '0;
      dq        <= '0;
      dd        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= '0;
            div_zero <= (op == OP_DIV) && (b == '0);
            mh       <= '0;
            ml       <= b;
            qm1      <= 1'b0;
            mcand    <= a;
            dr       <= '0;
            dq       <= a_mag;
            dd       <= b_mag;
            neg_q    <= a[MSB] ^ b[MSB];
            neg_r    <= a[MSB];
            if (op == OP_DIV) begin
              if (b == '0) begin
                result_lo <= '1;
                result_hi <= a;
              end
            end else if (op != OP_MUL) begin
              result_lo <= sc_res;
              result_hi <= '0;
            end
          end
        end
        S_MUL: begin
          mh  <= b_h;
          ml  <= b_l;
          qm1 <= ml[0];
          cnt <= cnt + 1'b1;
          if (last) begin
            result_hi <= b_h[WIDTH-1:0];
            result_lo <= b_l;
          end
        end
        S_DIV: begin
          dr  <= d_r;
          dq  <= d_q;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          result_lo <= fix_lo;
          result_hi <= fix_hi;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic sc_c;
  logic sc_v;

  always_comb begin
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (op)
      OP_ADD: begin
        sc_c = (a[MSB] & b[MSB]) | ((a[MSB] | b[MSB]) & ~sc_res[MSB]);
        sc_v = (a[MSB] == b[MSB]) && (sc_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_c = (a < b);
        sc_v = (a[MSB] != b[MSB]) && (sc_res[MSB] != a[MSB]);
      end
      OP_NEG: sc_v = (a == {1'b1, {(WIDTH-1){1'b0}}});
      OP_INC: begin
        sc_c = &b;
        sc_v = ~b[MSB] & sc_res[MSB];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (op == OP_DIV) && (b == '0)) begin
            flag_n <= 1'b1;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
          end else if (start && (op != OP_DIV) && (op != OP_MUL)) begin
            flag_n <= sc_res[MSB];
            flag_z <= (sc_res == '0);
            flag_c <= sc_c;
            flag_v <= sc_v;
          end
        end
        S_MUL: begin
          if (last) begin
            flag_n <= b_h[MSB];
            flag_z <= ({b_h[WIDTH-1:0], b_l} == '0);
            flag_c <= 1'b0;
            flag_v <= (b_h[WIDTH-1:0] != {WIDTH{b_l[MSB]}});
          end
        end
        S_FIX: begin
          flag_n <= fix_lo[MSB];
          flag_z <= (fix_lo == '0);
          flag_c <= 1'b0;
          flag_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule
